// File: rtl/gamepad_poller.sv
// gamepad_poller: SNES-protocol poller for two pads sharing one latch/clock pair
//   clk           vdp_clk
//   reset         asynchronous, active-high
//   start         single-cycle poll request (vdp_active_frame_ended)
//   busy          poll in progress
//   pad_latch     latch strobe to both pads
//   pad_clk       shift clock to both pads, idles high
//   pad_data      serial data, bit n = pad n, active-low, asynchronous
//   pad0_state    pad 0 buttons, active-high, bit 0 = first bit shifted
//   pad1_state    pad 1 buttons, same layout
//   state_valid   one-cycle pulse when pad*_state update
//   pad_connected per-pad connection flag
// Optional: GAMEPAD_POLLER_CONNECT_CHECK_EN enables unplugged-pad detection
//   (raw bits 15..12 must all read high); otherwise pad_connected is 2'b11.
module gamepad_poller #(
    parameter int HALF_PERIOD  = 300,
    parameter int LATCH_CYCLES = 600,
    parameter int PAD_BITS     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        pad_latch,
    output logic        pad_clk,
    input  logic [1:0]  pad_data,
    output logic [15:0] pad0_state,
    output logic [15:0] pad1_state,
    output logic        state_valid,
    output logic [1:0]  pad_connected
);
    localparam int MAXC = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (PAD_BITS > 1) ? $clog2(PAD_BITS) : 1;
    typedef enum logic [2:0] {IDLE, LATCH, HIGH, LOW, DONE} state_t;
    state_t              state;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [PAD_BITS-1:0] shift0, shift1;
    logic [1:0]          sync1, sync2;
    logic [1:0]          conn;
    logic                publish;
    // last LOW cycle of the final bit: results are registered on this edge so
    // they are visible during the DONE cycle together with state_valid
    assign publish = (state == LOW) && (cnt == '0) && (idx == IW'(PAD_BITS - 1));
`ifdef GAMEPAD_POLLER_CONNECT_CHECK_EN
    assign conn = {&shift1[15:12], &shift0[15:12]};
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pad_connected <= 2'b00;
        else if (publish)
            pad_connected <= conn;
    end
`else
    assign conn          = 2'b11;
    assign pad_connected = 2'b11;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            pad_latch   <= 1'b0;
            pad_clk     <= 1'b1;
            state_valid <= 1'b0;
            pad0_state  <= '0;
            pad1_state  <= '0;
            cnt         <= '0;
            idx         <= '0;
            shift0      <= '0;
            shift1      <= '0;
            sync1       <= '0;
            sync2       <= '0;
        end else begin
            sync1       <= pad_data;
            sync2       <= sync1;
            state_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= LATCH;
                    busy      <= 1'b1;
                    pad_latch <= 1'b1;
                    cnt       <= CW'(LATCH_CYCLES - 1);
                end
                LATCH: if (cnt == '0) begin
                    state     <= HIGH;
                    pad_latch <= 1'b0;
                    idx       <= '0;
                    cnt       <= CW'(HALF_PERIOD - 1);
                end else begin
                    cnt <= cnt - 1'b1;
                end
                HIGH: if (cnt == '0) begin
                    state       <= LOW;
                    pad_clk     <= 1'b0;
                    cnt         <= CW'(HALF_PERIOD - 1);
                    shift0[idx] <= sync2[0];
                    shift1[idx] <= sync2[1];
                end else begin
                    cnt <= cnt - 1'b1;
                end
                LOW: if (cnt == '0) begin
                    pad_clk <= 1'b1;
                    if (publish) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        state_valid <= 1'b1;
                        pad0_state  <= conn[0] ? 16'(~shift0) : 16'h0000;
                        pad1_state  <= conn[1] ? 16'(~shift1) : 16'h0000;
                    end else begin
                        state <= HIGH;
                        idx   <= idx + 1'b1;
                        cnt   <= CW'(HALF_PERIOD - 1);
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gamepad_poller.sv
// tb_gamepad_poller: directed bench for gamepad_poller with behavioural SNES pads
module tb_gamepad_poller;
    logic        clk = 1'b0;
    logic        reset, start;
    logic        busy, pad_latch, pad_clk, state_valid;
    logic [1:0]  pad_data, pad_connected;
    logic [15:0] pad0_state, pad1_state;
    logic [15:0] raw0 = 16'hFFFF, raw1 = 16'hFFFF;
    logic [4:0]  pos = '0;
    int n_cmp = 0, n_bad = 0;
    int v1, v2, vcount, latch_cnt, latch_first, low_cnt, falls, held_bad;
    logic        busy0;
    logic [15:0] s0, s1, p0, p1;
    logic [1:0]  c0;

    gamepad_poller #(.HALF_PERIOD(4), .LATCH_CYCLES(8), .PAD_BITS(16)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .pad_data(pad_data),
        .pad0_state(pad0_state), .pad1_state(pad1_state),
        .state_valid(state_valid), .pad_connected(pad_connected)
    );

    always #5 clk = ~clk;

    // pads: latch reloads bit 0, each rising pad_clk presents the next bit
    always @(posedge pad_latch or posedge pad_clk)
        if (pad_latch) pos <= '0;
        else           pos <= pos + 5'd1;
    assign pad_data = {raw1[pos[3:0]], raw0[pos[3:0]]};

`ifdef GAMEPAD_POLLER_CONNECT_CHECK_EN
    localparam logic [1:0] RST_CONN = 2'b00;
    function automatic logic [15:0] exp_state(input logic [15:0] r);
        return (&r[15:12]) ? ~r : 16'h0000;
    endfunction
    function automatic logic [1:0] exp_conn(input logic [15:0] r0, input logic [15:0] r1);
        return {&r1[15:12], &r0[15:12]};
    endfunction
`else
    localparam logic [1:0] RST_CONN = 2'b11;
    function automatic logic [15:0] exp_state(input logic [15:0] r);
        return ~r;
    endfunction
    function automatic logic [1:0] exp_conn(input logic [15:0] r0, input logic [15:0] r1);
        return (r0 === r1) ? 2'b11 : 2'b11;
    endfunction
`endif

    // k counts negedges after the edge that accepted start (k=0 follows edge T)
    task automatic run_poll(input int kmax, input int hold, input int pa, input int pb,
                            input int pc, input int chg_k, input logic [15:0] n0,
                            input logic [15:0] n1);
        logic prev_clk;
        v1 = -1; v2 = -1; vcount = 0; latch_cnt = 0; latch_first = -1;
        low_cnt = 0; falls = 0; held_bad = 0;
        @(negedge clk);
        p0 = pad0_state; p1 = pad1_state; prev_clk = pad_clk; start = 1'b1;
        for (int k = 0; k <= kmax; k++) begin
            @(negedge clk);
            if (k == 0) busy0 = busy;
            if (pad_latch) begin
                latch_cnt++;
                if (latch_first < 0) latch_first = k;
            end
            if (!pad_clk) low_cnt++;
            if (prev_clk && !pad_clk) falls++;
            prev_clk = pad_clk;
            if (state_valid) begin
                if (vcount == 0) begin
                    v1 = k; s0 = pad0_state; s1 = pad1_state; c0 = pad_connected;
                end else if (vcount == 1) v2 = k;
                vcount++;
            end else if (vcount == 0 && (pad0_state !== p0 || pad1_state !== p1)) held_bad++;
            if (k == chg_k) begin raw0 = n0; raw1 = n1; end
            start = (k < hold - 1) || k == pa || k == pb || k == pc;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        int bad_idle, nvalid;
        reset = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (pad_clk !== 1'b1)   begin n_bad++; $display("FAIL rst_pad_clk got %b exp 1", pad_clk); end
        n_cmp++; if (pad_latch !== 1'b0) begin n_bad++; $display("FAIL rst_pad_latch got %b exp 0", pad_latch); end
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_cmp++; if (state_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", state_valid); end
        n_cmp++; if (pad0_state !== 16'h0) begin n_bad++; $display("FAIL rst_pad0 got %h exp 0000", pad0_state); end
        n_cmp++; if (pad1_state !== 16'h0) begin n_bad++; $display("FAIL rst_pad1 got %h exp 0000", pad1_state); end
        n_cmp++; if (pad_connected !== RST_CONN) begin n_bad++; $display("FAIL rst_conn got %b exp %b", pad_connected, RST_CONN); end
        reset = 1'b0;
        bad_idle = 0; nvalid = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (state_valid) nvalid++;
            if (pad_clk !== 1'b1 || pad_latch !== 1'b0 || busy !== 1'b0 || pad0_state !== 16'h0) bad_idle++;
        end
        n_cmp++; if (nvalid !== 0)   begin n_bad++; $display("FAIL idle_valid got %0d exp 0", nvalid); end
        n_cmp++; if (bad_idle !== 0) begin n_bad++; $display("FAIL idle_outputs got %0d bad cycles exp 0", bad_idle); end
    endtask

    task automatic test_basic;
        raw0 = 16'hF0FE; raw1 = 16'hFFFF;
        run_poll(140, 1, -1, -1, -1, -1, 16'h0, 16'h0);
        n_cmp++; if (busy0 !== 1'b1)    begin n_bad++; $display("FAIL basic_busy got %b exp 1", busy0); end
        n_cmp++; if (latch_first !== 0) begin n_bad++; $display("FAIL basic_latch_start got %0d exp 0", latch_first); end
        n_cmp++; if (latch_cnt !== 8)   begin n_bad++; $display("FAIL basic_latch_len got %0d exp 8", latch_cnt); end
        n_cmp++; if (low_cnt !== 64)    begin n_bad++; $display("FAIL basic_low_cycles got %0d exp 64", low_cnt); end
        n_cmp++; if (falls !== 16)      begin n_bad++; $display("FAIL basic_falls got %0d exp 16", falls); end
        n_cmp++; if (vcount !== 1)      begin n_bad++; $display("FAIL basic_valid_count got %0d exp 1", vcount); end
        n_cmp++; if (v1 !== 136)        begin n_bad++; $display("FAIL basic_valid_time got %0d exp 136", v1); end
        n_cmp++; if (s0 !== 16'h0F01)   begin n_bad++; $display("FAIL basic_pad0 got %h exp 0f01", s0); end
        n_cmp++; if (s1 !== 16'h0000)   begin n_bad++; $display("FAIL basic_pad1 got %h exp 0000", s1); end
        n_cmp++; if (c0 !== 2'b11)      begin n_bad++; $display("FAIL basic_conn got %b exp 11", c0); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL basic_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_midpoll_change;
        logic [15:0] o0, o1, n0, n1;
        o0 = 16'hF234; o1 = 16'hFFF0; n0 = 16'hF5C3; n1 = 16'hF65A;
        raw0 = o0; raw1 = o1;
        // bits 0..5 are already sampled when the pads change after edge T+52
        run_poll(140, 1, -1, -1, -1, 52, n0, n1);
        n_cmp++; if (held_bad !== 0) begin n_bad++; $display("FAIL mid_held got %0d changed cycles exp 0", held_bad); end
        n_cmp++; if (v1 !== 136)     begin n_bad++; $display("FAIL mid_valid_time got %0d exp 136", v1); end
        n_cmp++; if (s0 !== exp_state((o0 & 16'h003F) | (n0 & 16'hFFC0)))
            begin n_bad++; $display("FAIL mid_pad0 got %h exp %h", s0, exp_state((o0 & 16'h003F) | (n0 & 16'hFFC0))); end
        n_cmp++; if (s1 !== exp_state((o1 & 16'h003F) | (n1 & 16'hFFC0)))
            begin n_bad++; $display("FAIL mid_pad1 got %h exp %h", s1, exp_state((o1 & 16'h003F) | (n1 & 16'hFFC0))); end
    endtask

    task automatic test_back_to_back;
        raw0 = 16'hFF00; raw1 = 16'hF0F0;
        // start held 3 cycles, re-pulsed at edges T+50 and T+137, new poll at T+140
        run_poll(280, 3, 49, 136, 139, -1, 16'h0, 16'h0);
        n_cmp++; if (vcount !== 2)  begin n_bad++; $display("FAIL b2b_valid_count got %0d exp 2", vcount); end
        n_cmp++; if (v1 !== 136)    begin n_bad++; $display("FAIL b2b_first_valid got %0d exp 136", v1); end
        n_cmp++; if (v2 !== 276)    begin n_bad++; $display("FAIL b2b_second_valid got %0d exp 276", v2); end
        n_cmp++; if (s0 !== 16'h00FF) begin n_bad++; $display("FAIL b2b_pad0 got %h exp 00ff", s0); end
        n_cmp++; if (s1 !== 16'h0F0F) begin n_bad++; $display("FAIL b2b_pad1 got %h exp 0f0f", s1); end
    endtask

    task automatic test_reset_mid;
        raw0 = 16'hF0FE; raw1 = 16'hF00F;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (59) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (pad_latch !== 1'b0 || pad_clk !== 1'b1 || busy !== 1'b0 || state_valid !== 1'b0)
            begin n_bad++; $display("FAIL rmid_ctrl got latch=%b clk=%b busy=%b valid=%b exp 0 1 0 0", pad_latch, pad_clk, busy, state_valid); end
        n_cmp++; if (pad0_state !== 16'h0 || pad1_state !== 16'h0)
            begin n_bad++; $display("FAIL rmid_states got %h %h exp 0000 0000", pad0_state, pad1_state); end
        n_cmp++; if (pad_connected !== RST_CONN) begin n_bad++; $display("FAIL rmid_conn got %b exp %b", pad_connected, RST_CONN); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        raw0 = 16'hFA50; raw1 = 16'hF00F;
        run_poll(140, 1, -1, -1, -1, -1, 16'h0, 16'h0);
        n_cmp++; if (v1 !== 136)      begin n_bad++; $display("FAIL rmid_valid_time got %0d exp 136", v1); end
        n_cmp++; if (s0 !== 16'h05AF) begin n_bad++; $display("FAIL rmid_pad0 got %h exp 05af", s0); end
        n_cmp++; if (s1 !== 16'h0FF0) begin n_bad++; $display("FAIL rmid_pad1 got %h exp 0ff0", s1); end
    endtask

    task automatic test_connect;
        raw0 = 16'hF7FF; raw1 = 16'h0000;
        run_poll(140, 1, -1, -1, -1, -1, 16'h0, 16'h0);
        n_cmp++; if (s0 !== 16'h0800) begin n_bad++; $display("FAIL conn_pad0 got %h exp 0800", s0); end
        n_cmp++; if (s1 !== exp_state(16'h0000)) begin n_bad++; $display("FAIL conn_pad1 got %h exp %h", s1, exp_state(16'h0000)); end
        n_cmp++; if (c0 !== exp_conn(16'hF7FF, 16'h0000))
            begin n_bad++; $display("FAIL conn_flags got %b exp %b", c0, exp_conn(16'hF7FF, 16'h0000)); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_midpoll_change;
        test_back_to_back;
        test_reset_mid;
        test_connect;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
